// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bus: the pipeline-side indices and control bits into the
// controller, and the forward/stall/flush/memory/perf outputs back.
interface pipeline_ctrl_if #(
  parameter int REG_AW     = 5,
  parameter int PERF_WIDTH = 16
);
  logic [REG_AW-1:0]     Rs1D;
  logic [REG_AW-1:0]     Rs2D;
  logic [REG_AW-1:0]     Rs1E;
  logic [REG_AW-1:0]     Rs2E;
  logic [REG_AW-1:0]     RdE;
  logic                  ResultSrcE0;
  logic                  PCSrcE;
  logic                  RegWriteM;
  logic [REG_AW-1:0]     RdM;
  logic                  RegWriteW;
  logic [REG_AW-1:0]     RdW;
  logic                  MemAccessM;
  logic                  MemReady;
  logic [1:0]            ForwardAE;
  logic [1:0]            ForwardBE;
  logic                  StallF;
  logic                  StallD;
  logic                  StallE;
  logic                  StallM;
  logic                  FlushD;
  logic                  FlushE;
  logic                  FlushW;
  logic                  MemReq;
  logic                  MemError;
  logic [PERF_WIDTH-1:0] StallCycles;
  logic [PERF_WIDTH-1:0] FlushCount;

  // Datapath / memory side: drives hazard inputs, consumes controls.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
           RegWriteM, RdM, RegWriteW, RdW, MemAccessM, MemReady,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemReq, MemError, StallCycles, FlushCount
  );

  // Controller side.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE,
           RegWriteM, RdM, RegWriteW, RdW, MemAccessM, MemReady,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushW, MemReq, MemError, StallCycles, FlushCount
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline:
// operand forwarding, load-use stalls, branch flushes, a wait-state FSM for
// variable-latency data memory with sticky timeout error, and saturating
// stall/flush performance counters.
module pipeline_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = 4,
  parameter int PERF_WIDTH  = 16
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } mem_state_e;

  localparam logic [REG_AW-1:0]     IDX_ZERO  = {REG_AW{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_LIMIT = CNT_WIDTH'(MEM_TIMEOUT);
  localparam logic [PERF_WIDTH-1:0] PERF_ONE  = {{(PERF_WIDTH-1){1'b0}}, 1'b1};

  mem_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PERF_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic [1:0] fwd_a_s, fwd_b_s;
  logic       lw_stall_s, mem_stall_s, mem_req_s;
  logic       stall_f_s, flush_d_s;

  // Forwarding selects: the younger result in M wins over the one in W; x0 never forwards.
  always_comb begin
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (bus.RegWriteM && (bus.RdM != IDX_ZERO) && (bus.RdM == bus.Rs1E)) begin
      fwd_a_s = 2'b10;
    end else if (bus.RegWriteW && (bus.RdW != IDX_ZERO) && (bus.RdW == bus.Rs1E)) begin
      fwd_a_s = 2'b01;
    end else begin
      fwd_a_s = 2'b00;
    end
    if (bus.RegWriteM && (bus.RdM != IDX_ZERO) && (bus.RdM == bus.Rs2E)) begin
      fwd_b_s = 2'b10;
    end else if (bus.RegWriteW && (bus.RdW != IDX_ZERO) && (bus.RdW == bus.Rs2E)) begin
      fwd_b_s = 2'b01;
    end else begin
      fwd_b_s = 2'b00;
    end
  end

  // Load-use detection: a load in E whose destination feeds the instruction in D.
  always_comb begin
    lw_stall_s = bus.ResultSrcE0 && (bus.RdE != IDX_ZERO) &&
                 ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
  end

  // Memory wait-state FSM: next state, wait counter, request and stall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_s   = 1'b0;
    mem_stall_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_req_s = bus.MemAccessM;
        if (bus.MemAccessM && !bus.MemReady) begin
          mem_stall_s = 1'b1;
          state_d     = ST_WAIT;
          cnt_d       = CNT_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        mem_req_s = bus.MemAccessM;
        if (bus.MemReady) begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_WIDTH{1'b0}};
        end else if (cnt_q == CNT_LIMIT) begin
          mem_stall_s = 1'b1;
          state_d     = ST_ERROR;
        end else begin
          mem_stall_s = 1'b1;
          cnt_d       = cnt_q + CNT_ONE;
        end
      end
      ST_ERROR: begin
        // Absorbing: the pipeline stays frozen until reset.
        mem_stall_s = 1'b1;
        state_d     = ST_ERROR;
      end
      default: begin
        mem_stall_s = 1'b1;
        state_d     = ST_ERROR;
      end
    endcase
  end

  // Stall/flush combination; a memory stall freezes everything, so a taken
  // branch held in E is only acted on once the memory access completes.
  always_comb begin
    stall_f_s = lw_stall_s || mem_stall_s;
    flush_d_s = bus.PCSrcE && !mem_stall_s;
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f_s && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + PERF_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_d_s && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + PERF_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_WIDTH{1'b0}};
      stall_cnt_q <= {PERF_WIDTH{1'b0}};
      flush_cnt_q <= {PERF_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Output drive; all controls are held inactive while reset is asserted.
  always_comb begin
    bus.ForwardAE   = 2'b00;
    bus.ForwardBE   = 2'b00;
    bus.StallF      = 1'b0;
    bus.StallD      = 1'b0;
    bus.StallE      = 1'b0;
    bus.StallM      = 1'b0;
    bus.FlushD      = 1'b0;
    bus.FlushE      = 1'b0;
    bus.FlushW      = 1'b0;
    bus.MemReq      = 1'b0;
    bus.MemError    = (state_q == ST_ERROR);
    bus.StallCycles = stall_cnt_q;
    bus.FlushCount  = flush_cnt_q;
    if (!rst) begin
      bus.ForwardAE = fwd_a_s;
      bus.ForwardBE = fwd_b_s;
      bus.StallF    = stall_f_s;
      bus.StallD    = stall_f_s;
      bus.StallE    = mem_stall_s;
      bus.StallM    = mem_stall_s;
      bus.FlushW    = mem_stall_s;
      bus.FlushD    = flush_d_s;
      bus.FlushE    = (lw_stall_s || bus.PCSrcE) && !mem_stall_s;
      bus.MemReq    = mem_req_s;
    end else begin
      bus.MemReq    = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl.
module tb_pipeline_ctrl;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  pipeline_ctrl_if #(.REG_AW(5), .PERF_WIDTH(16)) bus ();

  pipeline_ctrl #(
    .REG_AW(5), .MEM_TIMEOUT(15), .CNT_WIDTH(4), .PERF_WIDTH(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.Rs1D = 5'd0; bus.Rs2D = 5'd0; bus.Rs1E = 5'd0; bus.Rs2E = 5'd0;
    bus.RdE = 5'd0; bus.ResultSrcE0 = 1'b0; bus.PCSrcE = 1'b0;
    bus.RegWriteM = 1'b0; bus.RdM = 5'd0; bus.RegWriteW = 1'b0; bus.RdW = 5'd0;
    bus.MemAccessM = 1'b0; bus.MemReady = 1'b0;
  endtask

  // Advance to just after the next rising edge, ready to drive the next cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] stall_vec();
    return {bus.StallF, bus.StallD, bus.StallE, bus.StallM, bus.FlushW};
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    clear_inputs();
    // Inputs that would otherwise forward/stall/flush, all masked by reset.
    bus.RegWriteM = 1'b1; bus.RdM = 5'd5; bus.Rs1E = 5'd5;
    bus.ResultSrcE0 = 1'b1; bus.RdE = 5'd7; bus.Rs2D = 5'd7; bus.PCSrcE = 1'b1;
    #2;
    check_eq("rst_fwdA", bus.ForwardAE, 32'd0);
    check_eq("rst_stall", stall_vec(), 32'd0);
    check_eq("rst_flushE", bus.FlushE, 32'd0);
    check_eq("rst_cnt", bus.StallCycles, 32'd0);

    next_cycle();
    rst = 1'b0;
    clear_inputs();

    // Forwarding: M over W, x0 never forwards.
    bus.RegWriteM = 1'b1; bus.RdM = 5'd5; bus.RegWriteW = 1'b1; bus.RdW = 5'd5;
    bus.Rs1E = 5'd5; bus.Rs2E = 5'd3;
    @(negedge clk);
    check_eq("fwdA_M", bus.ForwardAE, 32'd2);
    check_eq("fwdB_none", bus.ForwardBE, 32'd0);
    next_cycle();
    bus.RdM = 5'd0;
    @(negedge clk);
    check_eq("fwdA_W", bus.ForwardAE, 32'd1);
    next_cycle();
    bus.RdM = 5'd3;
    @(negedge clk);
    check_eq("fwdB_M", bus.ForwardBE, 32'd2);
    check_eq("fwdA_W2", bus.ForwardAE, 32'd1);

    // Load-use stall for one cycle.
    next_cycle();
    clear_inputs();
    bus.ResultSrcE0 = 1'b1; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
    @(negedge clk);
    check_eq("lw_stallFD", {bus.StallF, bus.StallD}, 32'd3);
    check_eq("lw_flushE", bus.FlushE, 32'd1);
    check_eq("lw_stallE", bus.StallE, 32'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check_eq("lw_done", bus.StallF, 32'd0);
    check_eq("lw_cnt", bus.StallCycles, 32'd1);
    next_cycle();
    bus.ResultSrcE0 = 1'b1; bus.RdE = 5'd0;
    @(negedge clk);
    check_eq("lw_x0", {bus.StallF, bus.FlushE}, 32'd0);

    // Taken branch.
    next_cycle();
    clear_inputs();
    bus.PCSrcE = 1'b1;
    @(negedge clk);
    check_eq("br_flush", {bus.FlushD, bus.FlushE}, 32'd3);
    check_eq("br_stallF", bus.StallF, 32'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check_eq("br_cnt", bus.FlushCount, 32'd1);
    check_eq("br_done", bus.FlushD, 32'd0);

    // Memory access with 3 wait cycles.
    next_cycle();
    bus.MemAccessM = 1'b1; bus.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("mw_stall%0d", i), stall_vec(), 32'h1f);
      check_eq($sformatf("mw_req%0d", i), bus.MemReq, 32'd1);
      next_cycle();
    end
    bus.MemReady = 1'b1;
    @(negedge clk);
    check_eq("mw_ready", stall_vec(), 32'd0);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check_eq("mw_idle", bus.StallF, 32'd0);
    check_eq("mw_cnt", bus.StallCycles, 32'd4);

    // Zero-wait access.
    next_cycle();
    bus.MemAccessM = 1'b1; bus.MemReady = 1'b1;
    @(negedge clk);
    check_eq("zw_stall", stall_vec(), 32'd0);
    check_eq("zw_req", bus.MemReq, 32'd1);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check_eq("zw_idle", bus.StallF, 32'd0);
    check_eq("zw_cnt", bus.StallCycles, 32'd4);

    // Branch held in E during a memory wait.
    next_cycle();
    bus.MemAccessM = 1'b1; bus.MemReady = 1'b0; bus.PCSrcE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq($sformatf("pr_flush%0d", i), {bus.FlushD, bus.FlushE}, 32'd0);
      check_eq($sformatf("pr_stall%0d", i), bus.StallF, 32'd1);
      next_cycle();
    end
    bus.MemReady = 1'b1;
    @(negedge clk);
    check_eq("pr_release", {bus.FlushD, bus.FlushE, bus.StallF}, 32'd6);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check_eq("pr_fcnt", bus.FlushCount, 32'd2);
    check_eq("pr_scnt", bus.StallCycles, 32'd6);

    // Timeout into ERROR: IDLE cycle, then WAIT with cnt 1..15, then ERROR.
    next_cycle();
    bus.MemAccessM = 1'b1; bus.MemReady = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        check_eq("to_pre_err", bus.MemError, 32'd0);
        check_eq("to_pre_req", bus.MemReq, 32'd1);
      end
      if (i == 16) begin
        check_eq("to_err", bus.MemError, 32'd1);
        check_eq("to_req", bus.MemReq, 32'd0);
        check_eq("to_stall", stall_vec(), 32'h1f);
      end
      if (i < 16) next_cycle();
    end
    next_cycle();
    bus.MemAccessM = 1'b0; bus.MemReady = 1'b1;
    @(negedge clk);
    check_eq("to_sticky", bus.MemError, 32'd1);
    check_eq("to_stuck", bus.StallF, 32'd1);

    // Stall held long enough to saturate the stall counter.
    repeat (65541) @(posedge clk);
    @(negedge clk);
    check_eq("sat_scnt", bus.StallCycles, 32'hffff);

    // Asynchronous reset from ERROR.
    next_cycle();
    bus.MemAccessM = 1'b1; bus.PCSrcE = 1'b1;
    bus.RegWriteM = 1'b1; bus.RdM = 5'd5; bus.Rs1E = 5'd5;
    rst = 1'b1;
    #1;
    check_eq("ar_stall", stall_vec(), 32'd0);
    check_eq("ar_flush", {bus.FlushD, bus.FlushE}, 32'd0);
    check_eq("ar_req", bus.MemReq, 32'd0);
    check_eq("ar_err", bus.MemError, 32'd0);
    check_eq("ar_fwd", bus.ForwardAE, 32'd0);
    check_eq("ar_cnts", {bus.StallCycles, bus.FlushCount}, 32'd0);
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    bus.MemAccessM = 1'b1; bus.MemReady = 1'b0;
    @(negedge clk);
    check_eq("ar_idle_req", bus.MemReq, 32'd1);
    check_eq("ar_idle_stall", bus.StallF, 32'd1);
    check_eq("ar_idle_err", bus.MemError, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
